char_feature_scan: RTL
======================

CHAR_FEATURE_SCAN -- requirements
Module: char_feature_scan

Interface
REQ-001 SHALL have port clk, input, 1 -- pixel clock, all logic rising-edge.
REQ-002 SHALL have port rst_n, input, 1 -- reset, asynchronous, active-low.
REQ-003 SHALL have port i_x, input, 12 -- current pixel column.
REQ-004 SHALL have port i_y, input, 12 -- current pixel row.
REQ-005 SHALL have port pix_de, input, 1 -- pixel valid.
REQ-006 SHALL have port pix_bin, input, 1 -- binarized pixel, 1 = foreground.
REQ-007 SHALL have port frame_end, input, 1 -- single-cycle end-of-frame pulse.
REQ-008 SHALL have port part_lines, input, 72 -- six 12-bit partition columns, line1 in [11:0] through line6 in [71:60].
REQ-009 SHALL have port char_up, input, 12 -- top row of the character band.
REQ-010 SHALL have port char_down, input, 12 -- bottom row of the character band.
REQ-011 SHALL have port scan_line1, input, 12 -- first horizontal scan row.
REQ-012 SHALL have port scan_line2, input, 12 -- second horizontal scan row.
REQ-013 SHALL have port feat_valid, output, 1 -- feature record valid.
REQ-014 SHALL have port feat_ready, input, 1 -- consumer accepts record.
REQ-015 SHALL have port feat_idx, output, 3 -- cell index 0..4.
REQ-016 SHALL have port feat_cross1, output, 4 -- 0->1 transitions on scan_line1 in the cell.
REQ-017 SHALL have port feat_cross2, output, 4 -- 0->1 transitions on scan_line2 in the cell.
REQ-018 SHALL have port feat_pix, output, 12 -- foreground pixel count in the cell.
REQ-019 SHALL have port overrun, output, 1 -- sticky flag: a frame was dropped.

Function
REQ-020 SHALL define cell k (k = 0..4) as line(k+1) <= i_x < line(k+2), using unsigned 12-bit compares; cells with line(k+2) <= line(k+1) are empty and report zeros.
REQ-021 SHALL accumulate only when pix_de = 1 and char_up <= i_y <= char_down.
REQ-022 SHALL hold a previous-pixel bit per scan row; it clears to 0 when i_x enters a new cell, so a foreground pixel on a cell's first column counts as a crossing.
REQ-023 SHALL increment crossN[k] when i_y == scan_lineN and pix_bin rises 0->1 inside cell k; the count saturates at 15.
REQ-024 SHALL count pixels with pix_bin = 1 in cell k into pix[k]; the count saturates at 4095.
REQ-025 SHALL implement the states ACCUM (reset state) and REPORT.
REQ-026 SHALL, on frame_end in ACCUM, copy all accumulators to a snapshot, clear the accumulators on the same edge, and enter REPORT.
REQ-027 SHALL assert feat_valid in the cycle after frame_end, with feat_idx = 0.
REQ-028 SHALL hold the record stable while feat_valid = 1 and feat_ready = 0.
REQ-029 SHALL, on feat_valid & feat_ready, advance feat_idx; after idx 4 is accepted it SHALL drop feat_valid and return to ACCUM.
REQ-030 SHALL keep accumulating into the cleared accumulators during REPORT.
REQ-031 SHALL, on frame_end during REPORT, leave the snapshot and the record sequence untouched, clear the accumulators, and set overrun.
REQ-032 SHALL, when frame_end coincides with acceptance of idx 4, treat the event as occurring in ACCUM: take a new snapshot, re-enter REPORT at idx 0, and leave overrun unchanged.

Reset
REQ-033 SHALL, on rst_n low, asynchronously clear state to ACCUM and clear all accumulators, snapshot, feat_valid, feat_idx, feat_cross1, feat_cross2, feat_pix and overrun to 0; reset mid-REPORT discards the pending records.
REQ-034 SHALL clear overrun only by reset.

Configuration
REQ-035 SHALL compile the pixel counters only when CHAR_FEAT_PIXCNT_EN is defined; when it is undefined, feat_pix SHALL be constant 0 and no pixel-count registers SHALL exist.

Verification
REQ-036 Bench SHALL run: lines = 10,20,30,40,50,60; scan_line1 row pattern 0110 0110 in cell 0; frame_end -> idx 0 reports cross1 = 2, one cycle after frame_end.
REQ-037 Bench SHALL run: feat_ready held low for 5 cycles during idx 2 -> record stable, then idx 3 follows the first ready cycle.
REQ-038 Bench SHALL run: 20 rising edges in cell 1 on scan_line2 -> cross2 = 15 (saturated).
REQ-039 Bench SHALL run: second frame_end while idx 1 is pending -> overrun = 1, records for idx 1..4 unchanged.
REQ-040 Bench SHALL run: all-foreground 10x10 in cell 3 with the macro defined -> pix = 100; with the macro undefined -> pix = 0.
REQ-041 Bench SHALL run: rst_n pulse during REPORT -> feat_valid = 0 immediately, state ACCUM, overrun = 0.

Source files
------------

// File: rtl/char_feature_scan.sv
// char_feature_scan
// Per-frame character feature extractor. Five cells are defined by six
// partition columns. For each cell it counts 0->1 transitions on two
// horizontal scan rows and, optionally, foreground pixels. At end of frame
// the counters are snapshotted and streamed out as five valid/ready records.
// Optional build macro: CHAR_FEAT_PIXCNT_EN enables the foreground pixel
// counters; without it feat_pix is tied to zero.
module char_feature_scan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        pix_de,
  input  logic        pix_bin,
  input  logic        frame_end,
  input  logic [71:0] part_lines,
  input  logic [11:0] char_up,
  input  logic [11:0] char_down,
  input  logic [11:0] scan_line1,
  input  logic [11:0] scan_line2,
  output logic        feat_valid,
  input  logic        feat_ready,
  output logic [2:0]  feat_idx,
  output logic [3:0]  feat_cross1,
  output logic [3:0]  feat_cross2,
  output logic [11:0] feat_pix,
  output logic        overrun
);

  localparam int NCELL = 5;

  typedef enum logic [0:0] {ST_ACCUM = 1'b0, ST_REPORT = 1'b1} state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [2:0]       idx_next_s;
  logic [NCELL-1:0] in_cell_s;
  logic             acc_en_s;
  logic             hit1_s;
  logic             hit2_s;
  logic             accept_s;
  logic             last_accept_s;
  logic             take_snap_s;
  logic             set_ovr_s;
  logic [3:0]       acc_c1_r  [NCELL];
  logic [3:0]       acc_c2_r  [NCELL];
  logic [3:0]       snap_c1_r [NCELL];
  logic [3:0]       snap_c2_r [NCELL];
  logic [NCELL-1:0] prev1_r;
  logic [NCELL-1:0] prev2_r;
  logic             feat_valid_d_s;
  logic [2:0]       feat_idx_d_s;
  logic [3:0]       feat_c1_d_s;
  logic [3:0]       feat_c2_d_s;

  // Cell membership of the current column and pixel qualification.
  always_comb begin
    in_cell_s = '0;
    for (int k = 0; k < NCELL; k++) begin
      in_cell_s[k] = (i_x >= part_lines[12*k +: 12]) &&
                     (i_x <  part_lines[12*k+12 +: 12]);
    end
    acc_en_s = pix_de && (i_y >= char_up) && (i_y <= char_down);
    hit1_s   = acc_en_s && (i_y == scan_line1);
    hit2_s   = acc_en_s && (i_y == scan_line2);
  end

  // Crossing accumulators; the previous-pixel bit is kept per cell so that
  // entering a cell always starts from background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCELL; k++) begin
        acc_c1_r[k] <= 4'd0;
        acc_c2_r[k] <= 4'd0;
      end
      prev1_r <= '0;
      prev2_r <= '0;
    end else begin
      for (int k = 0; k < NCELL; k++) begin
        if (frame_end) begin
          acc_c1_r[k] <= 4'd0;
          acc_c2_r[k] <= 4'd0;
        end else begin
          if (hit1_s && in_cell_s[k] && pix_bin && !prev1_r[k] && (acc_c1_r[k] != 4'd15))
            acc_c1_r[k] <= acc_c1_r[k] + 4'd1;
          if (hit2_s && in_cell_s[k] && pix_bin && !prev2_r[k] && (acc_c2_r[k] != 4'd15))
            acc_c2_r[k] <= acc_c2_r[k] + 4'd1;
        end
      end
      if (hit1_s)
        prev1_r <= in_cell_s & {NCELL{pix_bin}};
      if (hit2_s)
        prev2_r <= in_cell_s & {NCELL{pix_bin}};
    end
  end

  // Snapshot of the crossing accumulators taken at an accepted frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCELL; k++) begin
        snap_c1_r[k] <= 4'd0;
        snap_c2_r[k] <= 4'd0;
      end
    end else if (take_snap_s) begin
      for (int k = 0; k < NCELL; k++) begin
        snap_c1_r[k] <= acc_c1_r[k];
        snap_c2_r[k] <= acc_c2_r[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_r <= ST_ACCUM;
    else
      state_r <= state_next_s;
  end

  // Next-state and record-index logic; a frame end coinciding with the
  // final acceptance behaves as if it arrived in ACCUM.
  always_comb begin
    accept_s      = (state_r == ST_REPORT) && feat_ready;
    last_accept_s = accept_s && (feat_idx == 3'd4);
    take_snap_s   = frame_end && ((state_r == ST_ACCUM) || last_accept_s);
    set_ovr_s     = frame_end && (state_r == ST_REPORT) && !last_accept_s;
    state_next_s  = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (frame_end) state_next_s = ST_REPORT;
        else           state_next_s = ST_ACCUM;
      end
      ST_REPORT: begin
        if (last_accept_s && !frame_end) state_next_s = ST_ACCUM;
        else                             state_next_s = ST_REPORT;
      end
      default: state_next_s = ST_ACCUM;
    endcase
    if (take_snap_s)        idx_next_s = 3'd0;
    else if (last_accept_s) idx_next_s = 3'd0;
    else if (accept_s)      idx_next_s = feat_idx + 3'd1;
    else                    idx_next_s = feat_idx;
  end

  // Output decode: next record contents, drawn from the snapshot as it will
  // be after this edge.
  always_comb begin
    feat_valid_d_s = (state_next_s == ST_REPORT);
    feat_idx_d_s   = 3'd0;
    feat_c1_d_s    = 4'd0;
    feat_c2_d_s    = 4'd0;
    if (feat_valid_d_s && (idx_next_s < 3'd5)) begin
      feat_idx_d_s = idx_next_s;
      if (take_snap_s) begin
        feat_c1_d_s = acc_c1_r[idx_next_s];
        feat_c2_d_s = acc_c2_r[idx_next_s];
      end else begin
        feat_c1_d_s = snap_c1_r[idx_next_s];
        feat_c2_d_s = snap_c2_r[idx_next_s];
      end
    end else begin
      feat_idx_d_s = 3'd0;
    end
  end

  // Registered record outputs and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_valid  <= 1'b0;
      feat_idx    <= 3'd0;
      feat_cross1 <= 4'd0;
      feat_cross2 <= 4'd0;
      overrun     <= 1'b0;
    end else begin
      feat_valid  <= feat_valid_d_s;
      feat_idx    <= feat_idx_d_s;
      feat_cross1 <= feat_c1_d_s;
      feat_cross2 <= feat_c2_d_s;
      overrun     <= overrun | set_ovr_s;
    end
  end

`ifdef CHAR_FEAT_PIXCNT_EN
  logic [11:0] acc_pix_r  [NCELL];
  logic [11:0] snap_pix_r [NCELL];
  logic [11:0] feat_pix_d_s;

  // Foreground pixel accumulators, saturating at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCELL; k++) acc_pix_r[k] <= 12'd0;
    end else begin
      for (int k = 0; k < NCELL; k++) begin
        if (frame_end)
          acc_pix_r[k] <= 12'd0;
        else if (acc_en_s && in_cell_s[k] && pix_bin && (acc_pix_r[k] != 12'd4095))
          acc_pix_r[k] <= acc_pix_r[k] + 12'd1;
      end
    end
  end

  // Snapshot of the pixel accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCELL; k++) snap_pix_r[k] <= 12'd0;
    end else if (take_snap_s) begin
      for (int k = 0; k < NCELL; k++) snap_pix_r[k] <= acc_pix_r[k];
    end
  end

  // Pixel-count field of the next record.
  always_comb begin
    feat_pix_d_s = 12'd0;
    if (feat_valid_d_s && (idx_next_s < 3'd5)) begin
      if (take_snap_s) feat_pix_d_s = acc_pix_r[idx_next_s];
      else             feat_pix_d_s = snap_pix_r[idx_next_s];
    end else begin
      feat_pix_d_s = 12'd0;
    end
  end

  // Registered pixel-count output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) feat_pix <= 12'd0;
    else        feat_pix <= feat_pix_d_s;
  end
`else
  assign feat_pix = 12'd0;
`endif

endmodule
